// File: rtl/mem_burst_convertor_if.sv
// Bus bundle for mem_burst_convertor: wide cache-side burst port plus
// narrow memory-side read port. The slave modport is the convertor's view.
interface mem_burst_convertor_if #(
  parameter int unsigned MEM_W     = 32,
  parameter int unsigned RATIO     = 2,
  parameter int unsigned MAX_BURST = 8
);
  localparam int unsigned CW = MEM_W * RATIO;
  localparam int unsigned BW = $clog2(MAX_BURST) + 1;

  // Cache side (wide beats)
  logic [31:0]    cache_address;
  logic           cache_read;
  logic [BW-1:0]  cache_burstcount;
  logic           cache_waitrequest;
  logic [CW-1:0]  cache_readdata;
  logic           cache_readdatavalid;

  // Memory side (narrow words)
  logic [31:0]    memory_address;
  logic           memory_read;
  logic           memory_waitrequest;
  logic [MEM_W-1:0] memory_readdata;
  logic           memory_readdatavalid;

  modport slave (
    input  cache_address, cache_read, cache_burstcount,
    output cache_waitrequest, cache_readdata, cache_readdatavalid,
    output memory_address, memory_read,
    input  memory_waitrequest, memory_readdata, memory_readdatavalid
  );

  modport master (
    output cache_address, cache_read, cache_burstcount,
    input  cache_waitrequest, cache_readdata, cache_readdatavalid,
    input  memory_address, memory_read,
    output memory_waitrequest, memory_readdata, memory_readdatavalid
  );
endinterface

// File: rtl/mem_burst_convertor.sv
// mem_burst_convertor: turns a wide cache burst read into a stream of narrow
// memory reads (bounded outstanding count) and reassembles the narrow
// responses little-endian into wide beats.
// Optional macro MEM_BURST_CONVERTOR_WRAP_EN: critical-word-first wrapping
// bursts (burstcount assumed power of two in that mode). Default: incrementing.
module mem_burst_convertor #(
  parameter int unsigned MEM_W     = 32,
  parameter int unsigned RATIO     = 2,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned MAX_OUTST = 4
) (
  input logic clock,
  input logic reset,
  mem_burst_convertor_if.slave bus
);
  localparam int unsigned CW         = MEM_W * RATIO;
  localparam int unsigned BW         = $clog2(MAX_BURST) + 1;
  localparam int unsigned BYTES_BEAT = CW / 8;
  localparam int unsigned STEP       = MEM_W / 8;
  localparam int unsigned RW         = BW + $clog2(RATIO);
  localparam int unsigned OW         = $clog2(MAX_OUTST + 1);
  localparam int unsigned IW         = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e         state_q, state_d;
  logic [31:0]    addr_q, addr_d;
  logic           rd_q, rd_d;
  logic [RW-1:0]  req_left_q, req_left_d;
  logic [BW-1:0]  beats_left_q, beats_left_d;
  logic [OW-1:0]  outst_q, outst_d;
  logic [IW-1:0]  widx_q, widx_d;
  logic [CW-1:0]  asm_q, asm_d;
  logic [CW-1:0]  rdata_q, rdata_d;
  logic           rvalid_q, rvalid_d;
  logic           cwait_q, cwait_d;
`ifdef MEM_BURST_CONVERTOR_WRAP_EN
  logic [31:0]    wmask_q, wmask_d;
`endif

  logic [BW-1:0]  bc_eff;
  logic           retire;
  logic           resp;
  logic           last_word;
  logic [31:0]    next_addr;

  // State register and datapath flops
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      rd_q         <= 1'b0;
      req_left_q   <= '0;
      beats_left_q <= '0;
      outst_q      <= '0;
      widx_q       <= '0;
      asm_q        <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      cwait_q      <= 1'b1;
`ifdef MEM_BURST_CONVERTOR_WRAP_EN
      wmask_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rd_q         <= rd_d;
      req_left_q   <= req_left_d;
      beats_left_q <= beats_left_d;
      outst_q      <= outst_d;
      widx_q       <= widx_d;
      asm_q        <= asm_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      cwait_q      <= cwait_d;
`ifdef MEM_BURST_CONVERTOR_WRAP_EN
      wmask_q      <= wmask_d;
`endif
    end
  end

  // Next-state, request issue, outstanding tracking and beat assembly
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rd_d         = rd_q;
    req_left_d   = req_left_q;
    beats_left_d = beats_left_q;
    outst_d      = outst_q;
    widx_d       = widx_q;
    asm_d        = asm_q;
    rdata_d      = rdata_q;
    rvalid_d     = 1'b0;
    cwait_d      = cwait_q;
`ifdef MEM_BURST_CONVERTOR_WRAP_EN
    wmask_d      = wmask_q;
`endif

    bc_eff    = (bus.cache_burstcount == '0) ? BW'(1) : bus.cache_burstcount;
    retire    = rd_q && !bus.memory_waitrequest;
    resp      = (state_q != IDLE) && bus.memory_readdatavalid;
    last_word = (widx_q == IW'(RATIO - 1));
`ifdef MEM_BURST_CONVERTOR_WRAP_EN
    // Offset advances modulo the burst size; upper address bits stay fixed
    next_addr = (addr_q & ~wmask_q) | ((addr_q + 32'(STEP)) & wmask_q);
`else
    next_addr = addr_q + 32'(STEP);
`endif

    case (state_q)
      IDLE: begin
        if (bus.cache_read && !cwait_q) begin
          state_d      = ISSUE;
          addr_d       = bus.cache_address & ~32'(BYTES_BEAT - 1);
          req_left_d   = RW'(32'(bc_eff) * RATIO);
          beats_left_d = bc_eff;
          widx_d       = '0;
`ifdef MEM_BURST_CONVERTOR_WRAP_EN
          wmask_d      = 32'(bc_eff) * 32'(BYTES_BEAT) - 32'd1;
`endif
        end
      end
      ISSUE: begin
        if (retire) begin
          req_left_d = req_left_q - RW'(1);
          addr_d     = next_addr;
          if (req_left_q == RW'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (resp && last_word && beats_left_q == BW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Little-endian assembly; the wide output only changes on a full beat
    if (resp) begin
      for (int k = 0; k < RATIO; k++) begin
        if (widx_q == IW'(k)) asm_d[k*MEM_W +: MEM_W] = bus.memory_readdata;
      end
      if (last_word) begin
        widx_d       = '0;
        rdata_d      = asm_d;
        rvalid_d     = 1'b1;
        beats_left_d = beats_left_q - BW'(1);
      end else begin
        widx_d = widx_q + IW'(1);
      end
    end

    // Retire and response in the same cycle cancel out
    if (retire && !resp) begin
      outst_d = outst_q + OW'(1);
    end else if (!retire && resp && outst_q != '0) begin
      outst_d = outst_q - OW'(1);
    end

    // A stalled request is held unchanged; otherwise issue while credit remains
    if (rd_q && bus.memory_waitrequest) begin
      rd_d = 1'b1;
    end else begin
      rd_d = (state_d == ISSUE) && (req_left_d != '0) && (outst_d < OW'(MAX_OUTST));
    end

    cwait_d = (state_d != IDLE);
  end

  assign bus.memory_address      = addr_q;
  assign bus.memory_read         = rd_q;
  assign bus.cache_readdata      = rdata_q;
  assign bus.cache_readdatavalid = rvalid_q;
  assign bus.cache_waitrequest   = cwait_q;
endmodule

// File: tb/tb_mem_burst_convertor.sv
// Directed testbench for mem_burst_convertor with a behavioural narrow memory
// (byte n reads as n[7:0]), configurable stall and response latency.
module tb_mem_burst_convertor;
  localparam int unsigned MEM_W     = 32;
  localparam int unsigned RATIO     = 2;
  localparam int unsigned MAX_BURST = 8;
  localparam int unsigned MAX_OUTST = 4;
  localparam int unsigned CW        = MEM_W * RATIO;
  localparam int unsigned BW        = $clog2(MAX_BURST) + 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_burst_convertor_if #(.MEM_W(MEM_W), .RATIO(RATIO), .MAX_BURST(MAX_BURST)) bus ();

  mem_burst_convertor #(
    .MEM_W(MEM_W), .RATIO(RATIO), .MAX_BURST(MAX_BURST), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Memory model state
  int stall_cfg = 0;
  int lat_cfg   = 1;
  int stall_cnt = 0;
  int cyc       = 0;
  int outst_m   = 0;
  int max_outst_m = 0;
  int stab_n    = 0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] retired[$];
  logic [CW-1:0] beats[$];
  bit          prev_stalled = 1'b0;
  logic [31:0] prev_addr    = '0;

  assign bus.memory_waitrequest = bus.memory_read && (stall_cnt < stall_cfg);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [MEM_W-1:0] mem_word(input logic [31:0] a);
    logic [MEM_W-1:0] r;
    for (int j = 0; j < 4; j++) r[j*8 +: 8] = 8'(a + 32'(j));
    return r;
  endfunction

  function automatic logic [CW-1:0] exp_beat(input logic [31:0] a);
    logic [CW-1:0] r;
    for (int j = 0; j < 8; j++) r[j*8 +: 8] = 8'(a + 32'(j));
    return r;
  endfunction

  // Narrow memory: sample at negedge, act just after the following posedge
  always begin
    logic        s_rd, s_wait, s_rv;
    logic [31:0] s_addr;
    @(negedge clock);
    s_rd   = bus.memory_read;
    s_wait = bus.memory_waitrequest;
    s_addr = bus.memory_address;
    s_rv   = bus.memory_readdatavalid;
    if (reset && prev_stalled) begin
      stab_n++;
      check("addr_stable", {31'd0, s_rd, s_addr}, {31'd0, 1'b1, prev_addr});
    end
    prev_stalled = s_rd && s_wait;
    prev_addr    = s_addr;
    @(posedge clock);
    #1;
    if (!reset) begin
      pend_addr.delete();
      pend_due.delete();
      bus.memory_readdatavalid = 1'b0;
      stall_cnt    = 0;
      outst_m      = 0;
      prev_stalled = 1'b0;
    end else begin
      cyc++;
      if (s_rv) outst_m--;
      if (s_rd && !s_wait) begin
        retired.push_back(s_addr);
        pend_addr.push_back(s_addr);
        pend_due.push_back(cyc + lat_cfg);
        stall_cnt = 0;
        outst_m++;
        if (outst_m > max_outst_m) max_outst_m = outst_m;
      end else if (s_rd && s_wait) begin
        stall_cnt++;
      end
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        bus.memory_readdata      = mem_word(pend_addr.pop_front());
        void'(pend_due.pop_front());
        bus.memory_readdatavalid = 1'b1;
      end else begin
        bus.memory_readdatavalid = 1'b0;
      end
    end
  end

  // Beat capture
  always @(negedge clock) begin
    if (bus.cache_readdatavalid) beats.push_back(bus.cache_readdata);
  end

  task automatic clear_logs();
    beats.delete();
    retired.delete();
    max_outst_m = 0;
    stab_n      = 0;
  endtask

  task automatic start_burst(input logic [31:0] a, input logic [BW-1:0] bc, output int waited);
    int n = 0;
    bus.cache_address    = a;
    bus.cache_burstcount = bc;
    bus.cache_read       = 1'b1;
    while (bus.cache_waitrequest && n < 500) begin
      @(posedge clock); #2;
      n++;
    end
    check("accept_timeout", 64'(n < 500), 64'd1);
    @(posedge clock); #2;
    bus.cache_read = 1'b0;
    waited = n;
  endtask

  task automatic wait_beats(input int cnt);
    int k = 0;
    while (beats.size() < cnt && k < 2000) begin
      @(posedge clock); #2;
      k++;
    end
    check("beats_timeout", 64'(k < 2000), 64'd1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (bus.cache_waitrequest && k < 2000) begin
      @(posedge clock); #2;
      k++;
    end
    check("idle_timeout", 64'(k < 2000), 64'd1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset                    = 1'b1;
    bus.cache_address        = '0;
    bus.cache_read           = 1'b0;
    bus.cache_burstcount     = '0;
    bus.memory_readdata      = '0;
    bus.memory_readdatavalid = 1'b0;
    #1 reset = 1'b0;

    // Reset values
    repeat (3) @(posedge clock);
    #2;
    check("rst_waitrequest", 64'(bus.cache_waitrequest), 64'd1);
    check("rst_memory_read", 64'(bus.memory_read), 64'd0);
    check("rst_memory_address", 64'(bus.memory_address), 64'd0);
    check("rst_readdata", 64'(bus.cache_readdata), 64'd0);
    check("rst_readdatavalid", 64'(bus.cache_readdatavalid), 64'd0);
    reset = 1'b1;
    #1;
    check("wait_before_edge", 64'(bus.cache_waitrequest), 64'd1);
    @(posedge clock); #2;
    check("wait_after_first_edge", 64'(bus.cache_waitrequest), 64'd0);

    // Incrementing burst 8, no stalls, latency 1
    clear_logs();
    start_burst(32'h0040_0000, 4'd8, w);
    wait_beats(8);
    wait_idle();
    check("a_nreads", 64'(retired.size()), 64'd16);
    for (int i = 0; i < 16; i++)
      check($sformatf("a_addr%0d", i), 64'(retired[i]), 64'(32'h0040_0000 + 32'(4 * i)));
    check("a_beat0", 64'(beats[0]), 64'h0706050403020100);
    check("a_beat7", 64'(beats[7]), 64'h3F3E3D3C3B3A3938);
    for (int i = 1; i < 7; i++)
      check($sformatf("a_beat%0d", i), 64'(beats[i]), 64'(exp_beat(32'h0040_0000 + 32'(8 * i))));

    // Three stall cycles on every request
    clear_logs();
    stall_cfg = 3;
    start_burst(32'h0040_0000, 4'd8, w);
    wait_beats(8);
    wait_idle();
    stall_cfg = 0;
    check("b_nreads", 64'(retired.size()), 64'd16);
    check("b_stall_seen", 64'(stab_n >= 48), 64'd1);
    for (int i = 0; i < 8; i++)
      check($sformatf("b_beat%0d", i), 64'(beats[i]), 64'(exp_beat(32'h0040_0000 + 32'(8 * i))));

    // Latency 10: outstanding limited to four
    clear_logs();
    lat_cfg = 10;
    start_burst(32'h0040_0080, 4'd8, w);
    wait_beats(8);
    wait_idle();
    lat_cfg = 1;
    check("c_max_outst", 64'(max_outst_m), 64'd4);
    check("c_nreads", 64'(retired.size()), 64'd16);
    for (int i = 0; i < 8; i++)
      check($sformatf("c_beat%0d", i), 64'(beats[i]), 64'(exp_beat(32'h0040_0080 + 32'(8 * i))));

    // Burst 8 starting mid-block
    clear_logs();
    start_burst(32'h0040_0010, 4'd8, w);
    wait_beats(8);
    wait_idle();
    check("d_nreads", 64'(retired.size()), 64'd16);
    check("d_beat0", 64'(beats[0]), 64'h1716151413121110);
`ifdef MEM_BURST_CONVERTOR_WRAP_EN
    check("d_addr11", 64'(retired[11]), 64'h0040003C);
    check("d_addr12", 64'(retired[12]), 64'h00400000);
    check("d_addr15", 64'(retired[15]), 64'h0040000C);
    check("d_beat6", 64'(beats[6]), 64'h0706050403020100);
    check("d_beat7", 64'(beats[7]), 64'h0F0E0D0C0B0A0908);
`else
    check("d_addr12", 64'(retired[12]), 64'h00400040);
    check("d_addr15", 64'(retired[15]), 64'h0040004C);
    check("d_beat7", 64'(beats[7]), 64'h4F4E4D4C4B4A4948);
`endif

    // Reset after beat 3 aborts the burst
    clear_logs();
    lat_cfg = 3;
    start_burst(32'h0040_0000, 4'd8, w);
    wait_beats(4);
    reset = 1'b0;
    check("e_beats_at_reset", 64'(beats.size()), 64'd4);
    #1;
    check("e_rst_read", 64'(bus.memory_read), 64'd0);
    check("e_rst_valid", 64'(bus.cache_readdatavalid), 64'd0);
    check("e_rst_wait", 64'(bus.cache_waitrequest), 64'd1);
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
    repeat (40) @(posedge clock);
    #2;
    check("e_no_beats_after", 64'(beats.size()), 64'd4);
    clear_logs();
    lat_cfg = 1;
    start_burst(32'h0000_0008, 4'd1, w);
    wait_beats(1);
    wait_idle();
    check("e_next_beat", 64'(beats[0]), 64'h0F0E0D0C0B0A0908);
    check("e_next_nreads", 64'(retired.size()), 64'd2);
    check("e_next_addr0", 64'(retired[0]), 64'h00000008);

    // cache_read held during DRAIN, burstcount 0
    clear_logs();
    lat_cfg = 6;
    start_burst(32'h0000_0000, 4'd2, w);
    begin
      int k = 0;
      while (retired.size() < 4 && k < 500) begin
        @(posedge clock); #2;
        k++;
      end
      check("f_drain_timeout", 64'(k < 500), 64'd1);
    end
    check("f_wait_in_drain", 64'(bus.cache_waitrequest), 64'd1);
    start_burst(32'h0000_0010, 4'd0, w);
    check("f_stalled_in_drain", 64'(w > 0), 64'd1);
    check("f_no_early_issue", 64'(retired.size()), 64'd4);
    wait_beats(3);
    wait_idle();
    repeat (30) @(posedge clock);
    #2;
    check("f_nbeats", 64'(beats.size()), 64'd3);
    check("f_beat0", 64'(beats[0]), 64'h0706050403020100);
    check("f_beat1", 64'(beats[1]), 64'h0F0E0D0C0B0A0908);
    check("f_beat2", 64'(beats[2]), 64'h1716151413121110);
    check("f_nreads", 64'(retired.size()), 64'd6);
    check("f_addr4", 64'(retired[4]), 64'h00000010);
    check("f_addr5", 64'(retired[5]), 64'h00000014);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
